// File: rtl/full_adder_8_pkg.sv
// full_adder_8_pkg
// Shared constants for the registered 8-bit ripple adder.
//   WIDTH    : operand width (fixed at 8)
//   SUM_RST  : value of sum after reset
//   COUT_RST : value of c_out after reset
package full_adder_8_pkg;

    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] SUM_RST  = '0;
    localparam logic             COUT_RST = 1'b0;

    // Full 9-bit result as seen on {c_out, sum}.
    typedef struct packed {
        logic             c_out;
        logic [WIDTH-1:0] sum;
    } add_result_t;

endpackage

// File: rtl/full_adder_8_fa_bit.sv
// fa_bit
// One-bit combinational full adder cell, chained to form the ripple adder.
// Ports:
//   a, b   : operand bits
//   c_in   : carry from the previous cell
//   sum    : sum bit
//   c_out  : carry to the next cell
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    logic prop;

    assign prop  = a ^ b;
    assign sum   = prop ^ c_in;
    assign c_out = (a & b) | (c_in & prop);

endmodule

// File: rtl/full_adder_8.sv
// full_adder_8
// Registered 8-bit unsigned adder built from a ripple chain of fa_bit cells.
// {c_out, sum} holds the 9-bit result of the operands sampled on the previous
// rising edge of clk.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous reset, active-high
//   a, b  : unsigned operands
//   c_in  : carry-in, present only when FULL_ADDER_8_CIN_EN is defined
//   sum   : registered result bits [7:0]
//   c_out : registered carry out of bit 7
// Build option:
//   FULL_ADDER_8_CIN_EN : adds the c_in port; otherwise carry-in is tied to 0.
module full_adder_8
    import full_adder_8_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef FULL_ADDER_8_CIN_EN
    input  logic             c_in,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_n;
    add_result_t      result_n;

`ifdef FULL_ADDER_8_CIN_EN
    assign carry[0] = c_in;
`else
    assign carry[0] = 1'b0;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_bit u_fa_bit (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .sum   (sum_n[i]),
            .c_out (carry[i+1])
        );
    end

    assign result_n.sum   = sum_n;
    assign result_n.c_out = carry[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            sum   <= SUM_RST;
            c_out <= COUT_RST;
        end else begin
            sum   <= result_n.sum;
            c_out <= result_n.c_out;
        end
    end

endmodule

// File: tb/tb_full_adder_8.sv
module tb_full_adder_8;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic [7:0] sum;
    logic       c_out;

    int vectors     = 0;
    int miscompares = 0;

    full_adder_8 dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
`ifdef FULL_ADDER_8_CIN_EN
        .c_in  (c_in),
`endif
        .sum   (sum),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what {c_out, sum} must read after each edge.
    logic [8:0] model_exp;
    logic       model_valid = 1'b0;
    int         cin_val;

    always @(posedge clk) begin
`ifdef FULL_ADDER_8_CIN_EN
        cin_val = (c_in === 1'b1) ? 1 : 0;
`else
        cin_val = 0;
`endif
        if (rst === 1'b1) begin
            model_exp   = 9'd0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            model_exp = 9'(int'(a) + int'(b) + cin_val);
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            vectors++;
            if ({c_out, sum} !== model_exp) begin
                miscompares++;
                $display("FAIL model t=%0t a=%h b=%h: got %h required %h",
                         $time, a, b, {c_out, sum}, model_exp);
            end
        end
    end

    task automatic apply(input logic [7:0] av, input logic [7:0] bv,
                         input logic r, input logic ci);
        @(negedge clk);
        a    = av;
        b    = bv;
        rst  = r;
        c_in = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [8:0] exp_v);
        vectors++;
        if ({c_out, sum} !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, {c_out, sum}, exp_v);
        end
    endtask

    initial begin
        rst  = 1'b1;
        a    = 8'hFF;
        b    = 8'hFF;
        c_in = 1'b0;

        apply(8'hFF, 8'hFF, 1'b1, 1'b0);
        check_lit("reset_edge1", 9'h000);
        apply(8'hFF, 8'hFF, 1'b1, 1'b0);
        check_lit("reset_edge2", 9'h000);
        apply(8'hFF, 8'hFF, 1'b0, 1'b0);
        check_lit("reset_release", 9'h1FE);

        apply(8'hFF, 8'h01, 1'b0, 1'b0);
        check_lit("carry_ff_01", 9'h100);
        apply(8'h80, 8'h80, 1'b0, 1'b0);
        check_lit("carry_80_80", 9'h100);

        apply(8'h12, 8'h34, 1'b0, 1'b0);
        check_lit("latency_12_34", 9'h046);
        apply(8'h12, 8'h34, 1'b0, 1'b0);
        check_lit("hold_1", 9'h046);
        apply(8'h12, 8'h34, 1'b0, 1'b0);
        check_lit("hold_2", 9'h046);

        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib++) begin
                if (ia == 100 && ib == 38) begin
                    apply(8'(ia), 8'(ib), 1'b1, 1'b0);
                    check_lit("midstream_reset", 9'h000);
                end
                apply(8'(ia), 8'(ib), 1'b0, 1'b0);
                if (ia == 0 && ib == 0)
                    check_lit("sweep_00_00", 9'h000);
                if (ia == 8'h7F && ib == 8'h01)
                    check_lit("sweep_7f_01", 9'h080);
                if (ia == 100 && ib == 38)
                    check_lit("reset_resume", 9'd138);
                if (ia == 255 && ib == 255)
                    check_lit("sweep_ff_ff", 9'h1FE);
            end
        end

`ifdef FULL_ADDER_8_CIN_EN
        apply(8'hFF, 8'h00, 1'b0, 1'b1);
        check_lit("cin_ff_00", 9'h100);
        apply(8'h00, 8'h00, 1'b0, 1'b1);
        check_lit("cin_00_00", 9'h001);
`endif

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
